// File: rtl/shreg_arb_pkg.sv
// rtl/shreg_arb_pkg.sv - shared types for the shared-register write arbiter
// Purpose: arbiter FSM state encoding, imported by shreg_wr_arbiter.
// Ports: none (package).
package shreg_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD   = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/shreg_arb_dffr.sv
// rtl/shreg_arb_dffr.sv - resettable D flip-flop bank
// Purpose: W-bit register with asynchronous active-low reset to RST_VAL.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   d_i    in  W  next value
//   q_o    out W  registered value
module shreg_arb_dffr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/shreg_arb_rr_pick.sv
// rtl/shreg_arb_rr_pick.sv - rotate-priority requester pick
// Purpose: combinational pick of the first valid requester starting at ptr_i,
//          wrapping from N_REQ-1 to 0 (N_REQ need not be a power of two).
// Ports:
//   req_valid_i  in  N_REQ  request vector
//   ptr_i        in  IDW    highest-priority index
//   gnt_o        out N_REQ  one-hot grant, zero when nothing is valid
//   gnt_id_o     out IDW    index of the granted requester (0 when none)
module shreg_arb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDW-1:0]   gnt_id_o
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // One extra bit so ptr+k cannot overflow before the modulo fold.
            sum = {1'b0, ptr_i} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N_REQ)) begin
                sum = sum - (IDW+1)'(N_REQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req_valid_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
    end

endmodule

// File: rtl/shreg_wr_arbiter.sv
// rtl/shreg_wr_arbiter.sv - round-robin write arbiter for one shared register
// Purpose: N_REQ requesters compete to write a WIDTH-bit register; one write
//          per grant, optional HOLDOFF idle cycles after each write.
//          Optional lock feature enabled by defining SHREG_ARB_LOCK_EN.
// Ports:
//   clk        in  1            rising-edge clock
//   rst_n      in  1            asynchronous active-low reset
//   req_valid  in  N_REQ        per-requester write request
//   req_data   in  N_REQ*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
//   req_lock   in  N_REQ        (SHREG_ARB_LOCK_EN only) keep grant after accept
//   req_ready  out N_REQ        grant, one-hot or zero
//   reg_q      out WIDTH        shared register value
//   reg_wr     out 1            pulse: reg_q updated this cycle
//   reg_wr_id  out IDW          requester index of the last write
//   busy       out 1            hold-off in progress, no grants
module shreg_wr_arbiter
    import shreg_arb_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int WIDTH   = 32,
    parameter  int HOLDOFF = 2,
    localparam int IDW     = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
`ifdef SHREG_ARB_LOCK_EN
    input  logic [N_REQ-1:0]       req_lock,
`endif
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       reg_q,
    output logic                   reg_wr,
    output logic [IDW-1:0]         reg_wr_id,
    output logic                   busy
);

    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    arb_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic [N_REQ-1:0] ready;
    logic             acc;
    logic             lock_acc;
    logic [IDW-1:0]   acc_id;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] reg_q_d;
    logic [IDW-1:0]   reg_wr_id_d;

    shreg_arb_rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        ready    = '0;
        acc_id   = gnt_id;
        wr_data  = '0;
        lock_acc = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                ready = gnt;
            end
            ARB_HOLD: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = ARB_IDLE;
                end
            end
`ifdef SHREG_ARB_LOCK_EN
            ARB_LOCKED: begin
                // Only the lock holder may write; ptr_q still points at it.
                ready[ptr_q] = req_valid[ptr_q];
                acc_id       = ptr_q;
            end
`endif
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // The grant must read as zero while reset is asserted, even though
        // the state register already shows ARB_IDLE.
        if (!rst_n) begin
            ready = '0;
        end

        acc = |(req_valid & ready);

        for (int i = 0; i < N_REQ; i++) begin
            if (acc_id == IDW'(i)) begin
                wr_data = req_data[i*WIDTH +: WIDTH];
            end
        end

`ifdef SHREG_ARB_LOCK_EN
        lock_acc = req_lock[acc_id];
`endif

        if (acc) begin
            if (lock_acc) begin
                state_d = ARB_LOCKED;
                ptr_d   = acc_id;
            end else begin
                ptr_d = (acc_id == IDW'(N_REQ - 1)) ? '0 : acc_id + IDW'(1);
                if (HOLDOFF > 0) begin
                    state_d = ARB_HOLD;
                    cnt_d   = CW'(HOLDOFF);
                end else begin
                    state_d = ARB_IDLE;
                end
            end
        end
    end

    assign req_ready   = ready;
    assign busy        = (state_q == ARB_HOLD);
    assign reg_q_d     = acc ? wr_data : reg_q;
    assign reg_wr_id_d = acc ? acc_id  : reg_wr_id;

    shreg_arb_dffr #(.W(WIDTH)) u_reg_q (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (reg_q_d),
        .q_o   (reg_q)
    );

    shreg_arb_dffr #(.W(1)) u_reg_wr (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (acc),
        .q_o   (reg_wr)
    );

    shreg_arb_dffr #(.W(IDW)) u_reg_wr_id (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (reg_wr_id_d),
        .q_o   (reg_wr_id)
    );

endmodule

// File: tb/tb_shreg_wr_arbiter.sv
// tb/tb_shreg_wr_arbiter.sv - directed table-driven bench for shreg_wr_arbiter
module tb_shreg_wr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // HOLDOFF=2, N_REQ=4
    logic [3:0]  v2 = '0;
    logic [31:0] d2 = 32'hA3A2A1A0;
    logic [3:0]  rdy2;
    logic [7:0]  q2;
    logic        wr2;
    logic [1:0]  id2;
    logic        busy2;
`ifdef SHREG_ARB_LOCK_EN
    logic [3:0]  lock2 = '0;
`endif

    // HOLDOFF=0, N_REQ=4
    logic [3:0]  v0 = '0;
    logic [31:0] d0 = 32'hA3A2A1A0;
    logic [3:0]  rdy0;
    logic [7:0]  q0;
    logic        wr0;
    logic [1:0]  id0;
    logic        busy0;
`ifdef SHREG_ARB_LOCK_EN
    logic [3:0]  lock0 = '0;
`endif

    // HOLDOFF=0, N_REQ=3 (non power of two wrap)
    logic [2:0]  v3 = '0;
    logic [23:0] d3 = 24'hC2C1C0;
    logic [2:0]  rdy3;
    logic [7:0]  q3;
    logic        wr3;
    logic [1:0]  id3;
    logic        busy3;
`ifdef SHREG_ARB_LOCK_EN
    logic [2:0]  lock3 = '0;
`endif

    shreg_wr_arbiter #(.N_REQ(4), .WIDTH(8), .HOLDOFF(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_data(d2),
`ifdef SHREG_ARB_LOCK_EN
        .req_lock(lock2),
`endif
        .req_ready(rdy2), .reg_q(q2), .reg_wr(wr2), .reg_wr_id(id2), .busy(busy2)
    );

    shreg_wr_arbiter #(.N_REQ(4), .WIDTH(8), .HOLDOFF(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_data(d0),
`ifdef SHREG_ARB_LOCK_EN
        .req_lock(lock0),
`endif
        .req_ready(rdy0), .reg_q(q0), .reg_wr(wr0), .reg_wr_id(id0), .busy(busy0)
    );

    shreg_wr_arbiter #(.N_REQ(3), .WIDTH(8), .HOLDOFF(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_data(d3),
`ifdef SHREG_ARB_LOCK_EN
        .req_lock(lock3),
`endif
        .req_ready(rdy3), .reg_q(q3), .reg_wr(wr3), .reg_wr_id(id3), .busy(busy3)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic [3:0] v;
        logic [3:0] rdy;
        logic       busy;
        logic       wr;
        logic [7:0] q;
        logic [1:0] id;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // rst, valid, ready, busy, wr, reg_q, id   (registered fields show the previous row's accept)
        tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[2]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 8'hA0, 2'd0};
        tbl[3]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'hA0, 2'd0};
        tbl[4]  = '{1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 8'hA0, 2'd0};
        tbl[5]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 8'hA2, 2'd2};
        tbl[6]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'hA2, 2'd2};
        tbl[7]  = '{1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 8'hA2, 2'd2};
        tbl[8]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 8'hA2, 2'd2};
        tbl[9]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'hA2, 2'd2};
        tbl[10] = '{1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 8'hA2, 2'd2};
        tbl[11] = '{1'b1, 4'b1001, 4'b0000, 1'b1, 1'b1, 8'hA2, 2'd2};
        tbl[12] = '{1'b1, 4'b1001, 4'b0000, 1'b1, 1'b0, 8'hA2, 2'd2};
        tbl[13] = '{1'b1, 4'b1001, 4'b1000, 1'b0, 1'b0, 8'hA2, 2'd2};
        tbl[14] = '{1'b1, 4'b1001, 4'b0000, 1'b1, 1'b1, 8'hA3, 2'd3};
        tbl[15] = '{1'b1, 4'b1001, 4'b0000, 1'b1, 1'b0, 8'hA3, 2'd3};
        tbl[16] = '{1'b1, 4'b1001, 4'b0001, 1'b0, 1'b0, 8'hA3, 2'd3};
        tbl[17] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'hA0, 2'd0};
        tbl[18] = '{1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[19] = '{1'b1, 4'b1001, 4'b0001, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[20] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'hA0, 2'd0};

        for (int r = 0; r < 21; r++) begin
            @(posedge clk);
            #1;
            rst_n = tbl[r].rst_n;
            v2    = tbl[r].v;
            @(negedge clk);
            chk($sformatf("row%0d ready", r), 32'(rdy2),  32'(tbl[r].rdy));
            chk($sformatf("row%0d busy", r),  32'(busy2), 32'(tbl[r].busy));
            chk($sformatf("row%0d reg_wr", r), 32'(wr2),  32'(tbl[r].wr));
            chk($sformatf("row%0d reg_q", r), 32'(q2),    32'(tbl[r].q));
            chk($sformatf("row%0d reg_wr_id", r), 32'(id2), 32'(tbl[r].id));
        end

        // Back-to-back writes, HOLDOFF=0, power-of-two and N_REQ=3 wrap.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        v2    = '0;
        @(negedge clk);
        chk("b2b reset ready0", 32'(rdy0), 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            v0 = (k < 5) ? 4'b1111 : 4'b0000;
            v3 = (k < 5) ? 3'b111  : 3'b000;
            @(negedge clk);
            if (k < 5) begin
                chk($sformatf("b2b%0d ready0", k), 32'(rdy0), 32'(4'b0001 << (k % 4)));
                chk($sformatf("b2b%0d ready3", k), 32'(rdy3), 32'(3'b001 << (k % 3)));
                chk($sformatf("b2b%0d busy0", k), 32'(busy0), 32'h0);
            end
            if (k >= 1) begin
                chk($sformatf("b2b%0d reg_wr0", k), 32'(wr0), 32'h1);
                chk($sformatf("b2b%0d reg_q0", k), 32'(q0), 32'(8'hA0 + 8'((k - 1) % 4)));
                chk($sformatf("b2b%0d id0", k), 32'(id0), 32'((k - 1) % 4));
                chk($sformatf("b2b%0d reg_wr3", k), 32'(wr3), 32'h1);
                chk($sformatf("b2b%0d reg_q3", k), 32'(q3), 32'(8'hC0 + 8'((k - 1) % 3)));
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b idle reg_wr0", 32'(wr0), 32'h0);
        chk("b2b idle reg_q0", 32'(q0), 32'hA0);

`ifdef SHREG_ARB_LOCK_EN
        begin
            logic [3:0] lv  [7];
            logic [3:0] ll  [7];
            logic [3:0] lr  [7];
            logic       lb  [7];
            logic       lw  [7];
            logic [7:0] lq  [7];
            lv = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000};
            ll = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
            lr = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
            lb = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b1,    1'b0,    1'b1};
            lw = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b0,    1'b0,    1'b1};
            lq = '{8'h00,   8'hA1,   8'hA1,   8'hA1,   8'hA1,   8'hA1,   8'hA0};
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(negedge clk);
            for (int c = 0; c < 7; c++) begin
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                v2    = lv[c];
                lock2 = ll[c];
                @(negedge clk);
                chk($sformatf("lock%0d ready", c), 32'(rdy2), 32'(lr[c]));
                chk($sformatf("lock%0d busy", c), 32'(busy2), 32'(lb[c]));
                chk($sformatf("lock%0d reg_wr", c), 32'(wr2), 32'(lw[c]));
                chk($sformatf("lock%0d reg_q", c), 32'(q2), 32'(lq[c]));
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
